// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int          CNT_W      = 4;
  localparam logic [31:0] RDATA_ZERO = 32'h0000_0000;
endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the CPU core (master) and the data memory (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; write and registered read share one enable.
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and a held response.
// Optional misalignment flagging is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);
  localparam logic [1:0]       S_IDLE    = ST_IDLE;
  localparam logic [1:0]       S_WAIT    = ST_WAIT;
  localparam logic [1:0]       S_RESP    = ST_RESP;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic                  r_mis;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;

  logic                  w_accept;
  logic                  w_go_resp;
  logic                  w_req_mis;
  logic                  w_we;
  logic                  w_mis;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  logic                  w_unused;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_req_mis = |bus.req_addr[1:0];
  assign w_unused  = ^bus.req_addr[31:ADDR_WIDTH+2];
  assign bus.resp_err = (r_state == S_RESP) && r_mis;
`else
  assign w_req_mis = 1'b0;
  assign w_unused  = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};
  assign bus.resp_err = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // The RAM is touched on the edge that enters RESP; with zero wait states
  // that is the accept edge itself, so the live request feeds the RAM.
  assign w_go_resp = !reset && ((w_accept && (WAIT_CYCLES == 0)) ||
                                ((r_state == S_WAIT) && (r_cnt == CNT_ONE)));
  assign w_we    = (r_state == S_IDLE) ? bus.req_we : r_we;
  assign w_mis   = (r_state == S_IDLE) ? w_req_mis : r_mis;
  assign w_idx   = (r_state == S_IDLE) ? bus.req_addr[ADDR_WIDTH+1:2] : r_idx;
  assign w_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk     (clk),
    .i_en    (w_go_resp),
    .i_we    (w_we && !w_mis),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_cnt   <= WAIT_INIT;
          r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_RESP;
        end
        S_RESP: if (bus.resp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request attributes are only consumed in WAIT/RESP, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_mis   <= w_req_mis;
      r_idx   <= bus.req_addr[ADDR_WIDTH+1:2];
      r_wdata <= bus.req_wdata;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = ((r_state == S_RESP) && !r_we && !r_mis) ? w_rdata : RDATA_ZERO;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;
  localparam int AW    = 10;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   bp_mode = 2;  // 0 random resp_ready, 1 held low, 2 held high

  logic [31:0] mem [2][DEPTH];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if b0();
  dmem_responder_if b1();

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut0 (
    .clk(clk), .reset(reset0), .bus(b0));
  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset1), .bus(b1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Reference: word-addressed memory, index wraps modulo depth.
  function automatic exp_t ref_access(input int port, input bit we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input int due);
    exp_t e;
    int   idx;
    bit   mis;
    idx = int'((addr / 4) % DEPTH);
    mis = MIS_EN && (addr % 4 != 0);
    if (we) begin
      if (!mis) mem[port][idx] = wdata;
      e.rdata = 32'h0;
    end else begin
      e.rdata = mis ? 32'h0 : mem[port][idx];
    end
    e.err = mis;
    e.due = due;
    return e;
  endfunction

  task automatic issue0(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit abort);
    int waited = 0;
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata;
    while (!b0.req_ready) begin
      if (waited++ > 100) begin
        timeout("accept0");
        b0.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    if (abort) begin
      reset0 = 1'b1;
      @(posedge clk); #1;
      reset0 = 1'b0;
      chk("abort_req_ready", b0.req_ready, 1);
      chk("abort_resp_valid", b0.resp_valid, 0);
      chk("abort_resp_rdata", b0.resp_rdata, 0);
      chk("abort_resp_err", b0.resp_err, 0);
    end else begin
      q0.push_back(ref_access(0, we, addr, wdata, cyc + WC));
    end
  endtask

  task automatic issue1(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int acc);
    int waited = 0;
    acc = -1;
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wdata;
    while (!b1.req_ready) begin
      if (waited++ > 100) begin
        timeout("accept1");
        b1.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    acc = cyc;
    q1.push_back(ref_access(1, we, addr, wdata, cyc));
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0) begin
      if (n++ > 300) begin
        timeout("drain0");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic seq0();
    logic [31:0] a;
    int n;
    issue0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    issue0(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    drain0();
    // Back-pressure: hold the load response for five cycles, then release.
    bp_mode = 1;
    issue0(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    n = 0;
    while (!b0.resp_valid && n < 50) begin @(negedge clk); n++; end
    if (!b0.resp_valid) timeout("bp_valid");
    repeat (5) @(negedge clk);
    bp_mode = 2;
    drain0();
    issue0(1'b1, 32'h0000_1004, 32'h1234_5678, 1'b0);
    issue0(1'b0, 32'h0000_0004, 32'h0, 1'b0);
    issue0(1'b1, 32'h0000_0020, 32'hAAAA_5555, 1'b1);
    issue0(1'b0, 32'h0000_0020, 32'h0, 1'b0);
    issue0(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 1'b0);
    issue0(1'b0, 32'h0000_0020, 32'h0, 1'b0);
    issue0(1'b0, 32'h0000_0021, 32'h0, 1'b0);
    drain0();
    bp_mode = 0;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue0(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end
    drain0();
    bp_mode = 2;
  endtask

  task automatic seq1();
    int acc;
    int prev;
    int n = 0;
    issue1(1'b1, 32'h0000_0040, 32'h0BAD_F00D, prev);
    for (int k = 0; k < 5; k++) begin
      issue1(1'b0, (k % 2 == 0) ? 32'h0000_0040 : 32'h0000_0044, 32'h0, acc);
      chk("throughput1", acc - prev, 2);
      prev = acc;
    end
    while (q1.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (q1.size() != 0) timeout("drain1");
  endtask

  initial begin : rr_drive
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        0: b0.resp_ready = ($urandom_range(0, 3) != 0);
        1: b0.resp_ready = 1'b0;
        default: b0.resp_ready = 1'b1;
      endcase
    end
  end

  initial begin : mon0
    bit pv = 1'b0;
    bit rdy_next = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset0) begin
        if (rdy_next) begin
          chk("ready_after_resp0", b0.req_ready, 1);
          rdy_next = 1'b0;
        end
        if (b0.resp_valid) begin
          if (q0.size() == 0) begin
            timeout("unexpected_resp0");
          end else begin
            if (!pv) chk("latency0", cyc, q0[0].due);
            chk("rdata0", b0.resp_rdata, q0[0].rdata);
            chk("err0", b0.resp_err, q0[0].err);
            chk("busy_ready0", b0.req_ready, 0);
            if (b0.resp_ready) begin
              void'(q0.pop_front());
              rdy_next = 1'b1;
            end
          end
        end
      end
      pv = b0.resp_valid && !b0.resp_ready;
    end
  end

  initial begin : mon1
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset1 && b1.resp_valid) begin
        if (q1.size() == 0) begin
          timeout("unexpected_resp1");
        end else begin
          if (!pv) chk("latency1", cyc, q1[0].due);
          chk("rdata1", b1.resp_rdata, q1[0].rdata);
          chk("err1", b1.resp_err, q1[0].err);
          if (b1.resp_ready) void'(q1.pop_front());
        end
      end
      pv = b1.resp_valid && !b1.resp_ready;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < DEPTH; i++) mem[p][i] = 32'h0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.resp_ready = 1'b1;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", b0.req_ready, 1);
    chk("rst_resp_valid", b0.resp_valid, 0);
    chk("rst_resp_rdata", b0.resp_rdata, 0);
    chk("rst_resp_err", b0.resp_err, 0);
    chk("rst_req_ready1", b1.req_ready, 1);
    chk("rst_resp_valid1", b1.resp_valid, 0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    fork
      seq0();
      seq1();
    join
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
